// File: rtl/uart_pkg.sv
// Shared types and constants for the UART serial line engine.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BIT_CNT_W = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last
// cycle of a bit period (full_tick) and the last cycle of its first half (half_tick).
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic full_tick,
    output logic half_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        full_tick = en && (cnt_q == FULL_LAST);
        half_tick = en && (cnt_q == HALF_LAST);
        cnt_d     = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = full_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART line engine: byte-wide valid/ready on the bridge side, serial
// TX/RX on the line side, each direction with its own baud counter.
module uart_phy
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      uart_txd,
    input  logic                      uart_rxd,
    output logic                      rx_frame_err,
    output logic                      rx_overrun,
    output uart_state_t               dbg_tx_state,
    output uart_state_t               dbg_rx_state
);

    // Handshakes: a byte moves on any rising clk edge where valid && ready are
    // both 1; valid, once raised, holds with stable data until that edge.
    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

    uart_state_t                 tx_state_q, tx_state_d;
    logic [UART_DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [UART_BIT_CNT_W-1:0]   tx_bit_q, tx_bit_d;
    logic                        tx_ready_q, tx_ready_d;
    logic                        txd_q, txd_d;
    logic                        tx_clr, tx_en, tx_full, tx_half_unused;

    uart_state_t                 rx_state_q, rx_state_d;
    logic [UART_DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [UART_BIT_CNT_W-1:0]   rx_bit_q, rx_bit_d;
    logic                        rx_valid_q, rx_valid_d;
    logic [UART_DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                        rx_ferr_q, rx_ferr_d;
    logic                        rx_ovr_q, rx_ovr_d;
    logic                        rx_clr, rx_en, rx_full, rx_half;
    logic [SYNC_STAGES-1:0]      sync_q, sync_d;
    logic                        rxs, rxs_prev_q;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
        .clk       (clk),
        .rst       (rst),
        .clr       (tx_clr),
        .en        (tx_en),
        .full_tick (tx_full),
        .half_tick (tx_half_unused)
    );

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
        .clk       (clk),
        .rst       (rst),
        .clr       (rx_clr),
        .en        (rx_en),
        .full_tick (rx_full),
        .half_tick (rx_half)
    );

    // uart_txd is registered, so each bit value is loaded one cycle ahead of its period.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_ready_d = tx_ready_q;
        txd_d      = txd_q;
        tx_clr     = 1'b0;
        tx_en      = (tx_state_q != IDLE);
        case (tx_state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_shift_d = tx_data;
                    tx_bit_d   = '0;
                    tx_clr     = 1'b1;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_full) begin
                    txd_d      = tx_shift_q[0];
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_full) begin
                    if (tx_bit_q == BIT_LAST) begin
                        txd_d      = 1'b1;
                        tx_state_d = STOP;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tx_full) begin
                    tx_ready_d = 1'b1;
                    tx_state_d = IDLE;
                end
            end
            default: begin
                tx_state_d = IDLE;
            end
        endcase
    end

    assign sync_d = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    assign rxs    = sync_q[SYNC_STAGES-1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_valid_d = rx_valid_q && !rx_ready;
        rx_data_d  = rx_data_q;
        rx_ferr_d  = 1'b0;
        rx_ovr_d   = 1'b0;
        rx_clr     = 1'b0;
        rx_en      = (rx_state_q != IDLE);
        case (rx_state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    rx_clr     = 1'b1;
                    rx_bit_d   = '0;
                    rx_state_d = START;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high level means a glitch.
                if (rx_half) begin
                    if (!rxs) begin
                        rx_clr     = 1'b1;
                        rx_state_d = DATA;
                    end else begin
                        rx_state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (rx_full) begin
                    rx_shift_d = {rxs, rx_shift_q[UART_DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (rx_full) begin
                    rx_state_d = IDLE;
                    if (!rxs) begin
                        rx_ferr_d = 1'b1;
                    end else if (rx_valid_q && !rx_ready) begin
                        rx_ovr_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                    end
                end
            end
            default: begin
                rx_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_ready_q <= 1'b1;
            txd_q      <= 1'b1;
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_ready_q <= tx_ready_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            sync_q     <= sync_d;
            rxs_prev_q <= rxs;
        end
    end

    assign tx_ready     = tx_ready_q;
    assign uart_txd     = txd_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_overrun   = rx_ovr_q;
    assign dbg_tx_state = tx_state_q;
    assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy: directed scenarios plus randomized full-duplex
// traffic compared every cycle against a frame-level behavioural model.
module tb_uart_phy;
    import uart_pkg::*;

    localparam int N    = 4;
    localparam int SYNC = 2;
    // Start edge -> rx_valid: synchronizer, edge-detect cycle, half a bit to the
    // start-bit centre, then nine whole bits to the stop-bit centre.
    localparam int RX_LAT = SYNC + 1 + N / 2 + 9 * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        tx_ready, rx_valid, uart_txd, rx_frame_err, rx_overrun;
    logic [7:0]  rx_data;
    uart_state_t dbg_tx_state, dbg_rx_state;

    uart_phy #(.CLKS_PER_BIT(N), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .uart_txd     (uart_txd),
        .uart_rxd     (uart_rxd),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .dbg_tx_state (dbg_tx_state),
        .dbg_rx_state (dbg_rx_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int         due;
        logic [7:0] data;
        bit         stop_ok;
    } rx_ev_t;

    rx_ev_t     rx_q[$];
    logic [7:0] exp_q[$];
    rx_ev_t     ev;
    int         cyc = 0;
    bit         tx_busy = 1'b0;
    int         tx_e0 = 0;
    logic [9:0] tx_frame = 10'h3FF;
    bit         hs;
    logic       m_txd = 1'b1, m_tx_ready = 1'b1;
    logic       m_rx_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            tx_busy    = 1'b0;
            m_rx_valid = 1'b0;
            m_rx_data  = 8'h00;
            m_ferr     = 1'b0;
            m_ovr      = 1'b0;
            rx_q.delete();
            exp_q.delete();
        end else begin
            if (!tx_busy && tx_valid) begin
                tx_busy  = 1'b1;
                tx_e0    = cyc;
                tx_frame = {1'b1, tx_data, 1'b0};
            end else if (tx_busy && (cyc - tx_e0 >= 10 * N)) begin
                tx_busy = 1'b0;
            end
            hs     = m_rx_valid && rx_ready;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (hs) m_rx_valid = 1'b0;
            if (rx_q.size() > 0 && rx_q[0].due == cyc) begin
                ev = rx_q.pop_front();
                if (!ev.stop_ok) begin
                    m_ferr = 1'b1;
                end else if (m_rx_valid) begin
                    m_ovr = 1'b1;
                end else begin
                    m_rx_valid = 1'b1;
                    m_rx_data  = ev.data;
                    exp_q.push_back(ev.data);
                end
            end
        end
        m_tx_ready = !tx_busy;
        m_txd      = tx_busy ? tx_frame[(cyc - tx_e0) / N] : 1'b1;
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_txd", 16'(uart_txd), 16'(m_txd));
            check("tx_ready", 16'(tx_ready), 16'(m_tx_ready));
            check("rx_valid", 16'(rx_valid), 16'(m_rx_valid));
            check("rx_data", 16'(rx_data), 16'(m_rx_data));
            check("rx_frame_err", 16'(rx_frame_err), 16'(m_ferr));
            check("rx_overrun", 16'(rx_overrun), 16'(m_ovr));
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rx_handshake_unexpected", 16'(rx_data), 16'hFFFF);
                end else begin
                    check("rx_handshake_data", 16'(rx_data), 16'(exp_q.pop_front()));
                end
            end
        end
    end

    logic rx_valid_prev = 1'b0;
    int   rise_cyc = 0, rise_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_valid_prev !== 1'b1) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        rx_valid_prev = rx_valid;
        if (rx_frame_err === 1'b1) ferr_cnt++;
        if (rx_overrun === 1'b1) ovr_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic send_rx(input logic [7:0] b, input bit stop_bit, output int s);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(posedge clk);
        #1;
        s = cyc;
        rx_q.push_back('{s + RX_LAT, b, stop_bit});
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (N) @(posedge clk);
            #1;
        end
        uart_rxd = 1'b1;
    endtask

    task automatic send_glitch();
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (3 * N) @(posedge clk);
    endtask

    task automatic pulse_rx_ready();
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic tx_a5_test();
        logic [40:0] txd_s, rdy_s;
        logic [9:0]  bits;
        int          zeros;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int j = 0; j <= 40; j++) begin
            txd_s[j] = uart_txd;
            rdy_s[j] = tx_ready;
            @(posedge clk);
            #1;
        end
        for (int b = 0; b < 10; b++) bits[b] = txd_s[b * N + N / 2];
        check("tx_a5_bits", 16'(bits), 16'(10'b11_0100_1010));
        zeros = 0;
        for (int j = 0; j < 40; j++) if (rdy_s[j] == 1'b0) zeros++;
        check("tx_a5_ready_low_cycles", 16'(zeros), 16'd40);
        check("tx_a5_ready_back", 16'(rdy_s[40]), 16'd1);
    endtask

    task automatic tx_reset_test();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (4 * N + 1) @(posedge clk);
        #1;
        check("tx_bit3_before_rst", 16'(uart_txd), 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("tx_rst_txd", 16'(uart_txd), 16'd1);
        check("tx_rst_ready", 16'(tx_ready), 16'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, r0, f0, o0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_ready", 16'(tx_ready), 16'd1);
        check("rst_uart_txd", 16'(uart_txd), 16'd1);
        check("rst_rx_valid", 16'(rx_valid), 16'd0);
        check("rst_rx_data", 16'(rx_data), 16'd0);
        check("rst_frame_err", 16'(rx_frame_err), 16'd0);
        check("rst_overrun", 16'(rx_overrun), 16'd0);
        check("rst_tx_state", 16'(dbg_tx_state), 16'(IDLE));
        check("rst_rx_state", 16'(dbg_rx_state), 16'(IDLE));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        tx_a5_test();

        send_rx(8'h3C, 1'b1, s);
        repeat (2) @(posedge clk);
        #1;
        check("rx_3c_latency", 16'(rise_cyc - s), 16'd41);
        check("rx_3c_data", 16'(rx_data), 16'h3C);
        repeat (3) @(posedge clk);
        #1;
        check("rx_3c_held", 16'({rx_valid, rx_data}), 16'h13C);
        pulse_rx_ready();
        check("rx_3c_cleared", 16'(rx_valid), 16'd0);

        o0 = ovr_cnt;
        f0 = ferr_cnt;
        send_rx(8'h11, 1'b1, s);
        send_rx(8'h22, 1'b1, s);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_pulses", 16'(ovr_cnt - o0), 16'd1);
        check("ovr_data_kept", 16'(rx_data), 16'h11);
        check("ovr_no_ferr", 16'(ferr_cnt - f0), 16'd0);
        pulse_rx_ready();

        r0 = rise_cnt;
        f0 = ferr_cnt;
        send_rx(8'h55, 1'b0, s);
        repeat (3) @(posedge clk);
        #1;
        check("ferr_pulses", 16'(ferr_cnt - f0), 16'd1);
        check("ferr_no_valid", 16'(rise_cnt - r0), 16'd0);
        check("ferr_rx_valid", 16'(rx_valid), 16'd0);

        r0 = rise_cnt;
        send_glitch();
        repeat (2) @(posedge clk);
        #1;
        check("glitch_no_valid", 16'(rise_cnt - r0), 16'd0);
        check("glitch_rx_idle", 16'(dbg_rx_state), 16'(IDLE));

        tx_reset_test();

        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    tx_valid = ($urandom_range(0, 3) != 0);
                    tx_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
                tx_valid = 1'b0;
            end
            begin
                int rs;
                for (int k = 0; k < 25; k++) begin
                    case ($urandom_range(0, 9))
                        0:       send_glitch();
                        1:       send_rx(8'($urandom), 1'b0, rs);
                        default: send_rx(8'($urandom), 1'b1, rs);
                    endcase
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 1400; i++) begin
                    rx_ready = ($urandom_range(0, 2) == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        rx_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
